// File: rtl/neuron_par_mac.sv
// Fully connected neuron: PAR-lane signed MAC pipeline, saturating accumulate, bias, ReLU/linear.
// Define NEURON_ROUND_EN to round half-up instead of truncating on the final >>> FRAC.
module neuron_par_mac #(
  parameter int LAYER_NO   = 0,
  parameter int NEURON_NO  = 0,
  parameter int NUM_WEIGHT = 784,
  parameter int PAR        = 4,
  parameter int DW         = 16,
  parameter int WIF        = 1,
  parameter     ACT        = "relu"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAR*DW-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wt_valid,
  input  logic              bias_valid,
  input  logic [31:0]       weightValue,
  input  logic [31:0]       biasValue,
  input  logic [31:0]       config_layer_num,
  input  logic [31:0]       config_neuron_num,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wt_err
);
  localparam int FRAC = DW - 1 - WIF;
  localparam int NB   = (NUM_WEIGHT + PAR - 1) / PAR;
  localparam int LP   = (PAR > 1) ? $clog2(PAR) : 0;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW   = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam int SW   = 2 * DW;
  localparam int TW   = SW + LP;

  localparam logic signed [SW-1:0] SMAX     = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN     = {1'b1, {(SW-1){1'b0}}};
  localparam logic signed [DW-1:0] DMAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] DMIN     = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [SW-1:0] RND_HALF = SW'(1) << (FRAC - 1);

  typedef enum logic [2:0] {IDLE, ACC, BIAS, ACT_S, OUT} state_t;
  state_t state;

  logic [BW-1:0]         cnt;
  logic [PW-1:0]         wr_ptr;
  logic signed [DW-1:0]  bias;
  logic signed [SW-1:0]  sum;
  logic signed [TW-1:0]  tree_sum, tree_reg;
  logic signed [SW-1:0]  prod_vec [PAR];
  logic                  all_in, v1, v2, v3, l1, l2, l3, acc_last;

  logic cfg_match, wr_en, bias_en, last_beat, take;
  logic unused_bits;

  assign cfg_match = (config_layer_num == 32'(LAYER_NO)) && (config_neuron_num == 32'(NEURON_NO));
  assign wr_en     = cfg_match && wt_valid && (state == IDLE);
  assign bias_en   = cfg_match && bias_valid && (state == IDLE);
  assign last_beat = (cnt == BW'(NB - 1));
  assign in_ready  = (state == IDLE) || ((state == ACC) && !all_in);
  assign take      = in_valid && in_ready;
  assign unused_bits = ^{weightValue[31:DW], biasValue[31:DW]};

  function automatic logic signed [SW-1:0] sat_add(input logic signed [SW-1:0] a,
                                                   input logic signed [TW-1:0] b);
    logic signed [TW:0] s;
    s = (TW+1)'(a) + (TW+1)'(b);
    if (s > (TW+1)'(SMAX))      sat_add = SMAX;
    else if (s < (TW+1)'(SMIN)) sat_add = SMIN;
    else                        sat_add = SW'(s);
  endfunction

  // One RAM bank per lane: weight index i lives in bank i%PAR at row i/PAR.
  for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
    logic signed [DW-1:0] mem [NB];
    logic signed [DW-1:0] w_rd, x_d;
    logic signed [SW-1:0] prod;
    logic                 lane_en;

    assign lane_en = (int'(cnt) * PAR + gi) < NUM_WEIGHT;

    always_ff @(posedge clk) begin
      if (wr_en && ((int'(wr_ptr) % PAR) == gi))
        mem[BW'(int'(wr_ptr) / PAR)] <= weightValue[DW-1:0];
      if (take) begin
        w_rd <= mem[cnt];
        x_d  <= lane_en ? in_data[gi*DW +: DW] : '0;
      end
      prod <= w_rd * x_d;
    end
    assign prod_vec[gi] = prod;
  end

  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < PAR; k++) tree_sum = tree_sum + TW'(prod_vec[k]);
  end

  logic signed [SW-1:0] bias_sh, rnd, shifted;
  logic signed [DW-1:0] sat_val, act_val;

  assign bias_sh = SW'(bias) <<< FRAC;

  always_comb begin
    rnd = sum;
`ifdef NEURON_ROUND_EN
    rnd = sat_add(sum, TW'(RND_HALF));
`endif
    shifted = rnd >>> FRAC;
    if (shifted > SW'(DMAX))      sat_val = DMAX;
    else if (shifted < SW'(DMIN)) sat_val = DMIN;
    else                          sat_val = DW'(shifted);
  end

  if (ACT == "linear") begin : g_linear
    assign act_val = sat_val;
  end else begin : g_relu
    assign act_val = sat_val[DW-1] ? '0 : sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ptr   <= '0;
      bias     <= '0;
      sum      <= '0;
      tree_reg <= '0;
      all_in   <= 1'b0;
      {v1, v2, v3, l1, l2, l3, acc_last} <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      wt_err    <= 1'b0;
    end else begin
      v1 <= take;
      l1 <= take && last_beat;
      v2 <= v1;
      l2 <= l1;
      v3 <= v2;
      l3 <= l2;
      tree_reg <= tree_sum;
      acc_last <= v3 && l3;
      if (v3) sum <= sat_add(sum, tree_reg);
      if (take) cnt <= last_beat ? '0 : cnt + 1'b1;
      if (wr_en) wr_ptr <= (wr_ptr == PW'(NUM_WEIGHT - 1)) ? '0 : wr_ptr + 1'b1;
      if (bias_en) bias <= biasValue[DW-1:0];
      if (cfg_match && (wt_valid || bias_valid) && (state != IDLE)) wt_err <= 1'b1;

      case (state)
        IDLE: if (take) begin
          state  <= ACC;
          all_in <= last_beat;
        end
        ACC: begin
          if (take && last_beat) all_in <= 1'b1;
          if (acc_last) state <= BIAS;
        end
        BIAS: begin
          sum   <= sat_add(sum, TW'(bias_sh));
          state <= ACT_S;
        end
        ACT_S: begin
          out_data  <= act_val;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          sum       <= '0;
          all_in    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_par_mac.sv
// Randomized + directed bench for neuron_par_mac against an arithmetic reference model.
// Honours NEURON_ROUND_EN in the model when the RTL is built with it.
module tb_neuron_par_mac;
  localparam int DW = 16, PAR = 4, NW = 6, FRAC = 14, NB = 2;
  localparam int LAYER = 2, NEURON = 5;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  logic clk = 1'b0;
  logic rst;
  logic [PAR*DW-1:0] in_data;
  logic in_valid, wt_valid, bias_valid, out_ready;
  logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num;
  logic in_ready, out_valid, wt_err, in_ready_l, out_valid_l, wt_err_l;
  logic [DW-1:0] out_data, out_data_l;

  always #5 clk = ~clk;

  neuron_par_mac #(.LAYER_NO(LAYER), .NEURON_NO(NEURON), .NUM_WEIGHT(NW), .PAR(PAR),
                   .DW(DW), .WIF(1), .ACT("relu")) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wt_valid(wt_valid), .bias_valid(bias_valid), .weightValue(weightValue),
    .biasValue(biasValue), .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .wt_err(wt_err));

  neuron_par_mac #(.LAYER_NO(LAYER), .NEURON_NO(NEURON), .NUM_WEIGHT(NW), .PAR(PAR),
                   .DW(DW), .WIF(1), .ACT("linear")) u_lin (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
    .wt_valid(wt_valid), .bias_valid(bias_valid), .weightValue(weightValue),
    .biasValue(biasValue), .config_layer_num(config_layer_num),
    .config_neuron_num(config_neuron_num), .out_data(out_data_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .wt_err(wt_err_l));

  int checks = 0, passed = 0;
  int wv[NW], xv[NW], bv;
  logic [15:0] exp_r, exp_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Fixed-point dot product, accumulated beat by beat with 32-bit saturation.
  task automatic model();
    longint sum, p, s;
    sum = 0;
    for (int bt = 0; bt < NB; bt++) begin
      p = 0;
      for (int k = 0; k < PAR; k++)
        if (bt * PAR + k < NW) p += longint'(wv[bt*PAR+k]) * longint'(xv[bt*PAR+k]);
      sum = clamp(sum + p, SMIN, SMAX);
    end
    sum = clamp(sum + longint'(bv) * (64'sd1 << FRAC), SMIN, SMAX);
`ifdef NEURON_ROUND_EN
    sum = clamp(sum + (64'sd1 << (FRAC - 1)), SMIN, SMAX);
`endif
    s = clamp(sum >>> FRAC, -32768, 32767);
    exp_l = 16'(s);
    exp_r = (s < 0) ? 16'h0000 : 16'(s);
  endtask

  task automatic load();
    for (int i = 0; i < NW; i++) begin
      @(negedge clk);
      config_layer_num = LAYER; config_neuron_num = NEURON;
      wt_valid = 1'b1; weightValue = 32'(wv[i]);
    end
    @(negedge clk);
    wt_valid = 1'b0; bias_valid = 1'b1; biasValue = 32'(bv);
    @(negedge clk);
    bias_valid = 1'b0;
  endtask

  task automatic run_vec(input string tag, input bit gaps, input int hold, input bit inject);
    int beat, lat, guard, idx;
    logic [15:0] held_r;
    beat = 0; guard = 0;
    while (beat < NB && guard < 100) begin
      @(negedge clk);
      guard++;
      wt_valid = 1'b0;
      config_neuron_num = NEURON;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int k = 0; k < PAR; k++) begin
          idx = beat * PAR + k;
          in_data[k*DW +: DW] = (idx < NW) ? 16'(xv[idx]) : 16'($urandom);
        end
        if (inject && beat == 1) begin
          wt_valid = 1'b1; weightValue = 32'h7FFF;
        end else if (gaps && beat == 1) begin
          wt_valid = 1'b1; weightValue = 32'h7FFF; config_neuron_num = NEURON + 1;
        end
        if (in_ready) beat++;
      end
    end
    check({tag, "_beats"}, beat, NB);
    @(negedge clk);
    in_valid = 1'b0; wt_valid = 1'b0; config_neuron_num = NEURON;
    lat = 1;
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, 7);
    check({tag, "_relu"}, out_data, exp_r);
    check({tag, "_lin"}, out_data_l, exp_l);
    held_r = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hold_ov"}, out_valid, 1);
      check({tag, "_hold_data"}, out_data, held_r);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_consumed"}, out_valid, 0);
    $display("vec %s: relu=0x%04h lin=0x%04h exp=0x%04h/0x%04h lat=%0d",
             tag, out_data, out_data_l, exp_r, exp_l, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; wt_valid = 1'b0; bias_valid = 1'b0;
    out_ready = 1'b0; weightValue = '0; biasValue = '0;
    config_layer_num = LAYER; config_neuron_num = NEURON;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_wt_err", wt_err, 0);
    rst = 1'b0;

    // Directed values: 0x4000 = 1.0, 0x0800 = 0.125, 0x1000 = 0.25, 0xC000 = -1.0
    foreach (wv[i]) begin wv[i] = 16'sh0800; xv[i] = 16'sh4000; end
    bv = 16'sh1000;
    load(); exp_r = 16'h4000; exp_l = 16'h4000;
    run_vec("d_bias_pos", 0, 0, 0);
    bv = -16384;
    load(); exp_r = 16'h0000; exp_l = 16'hF000;
    run_vec("d_bias_neg", 0, 0, 0);
    foreach (wv[i]) wv[i] = 16'sh2000;
    bv = 0;
    load(); exp_r = 16'h7FFF; exp_l = 16'h7FFF;
    run_vec("d_sat", 0, 0, 0);
    foreach (wv[i]) begin wv[i] = 0; xv[i] = 0; end
    wv[0] = 16'sh2000; xv[0] = 1;
    load();
`ifdef NEURON_ROUND_EN
    exp_r = 16'h0001; exp_l = 16'h0001;
`else
    exp_r = 16'h0000; exp_l = 16'h0000;
`endif
    run_vec("d_round", 0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      foreach (wv[i]) begin
        wv[i] = int'($urandom_range(0, 32766)) - 16383;
        xv[i] = int'($urandom_range(0, 32766)) - 16383;
      end
      bv = int'($urandom_range(0, 32766)) - 16383;
      load(); model();
      run_vec($sformatf("r%0d", n), 1, int'($urandom_range(0, 2)), 0);
    end
    check("unmatched_no_err", wt_err, 0);

    foreach (wv[i]) begin wv[i] = 16'sh0800; xv[i] = 16'sh4000; end
    bv = 16'sh1000;
    load(); exp_r = 16'h4000; exp_l = 16'h4000;
    run_vec("err_inject", 0, 5, 1);
    check("wt_err_set", wt_err, 1);
    run_vec("err_ram_kept", 0, 0, 0);
    check("wt_err_sticky", wt_err, 1);

    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < PAR; k++) in_data[k*DW +: DW] = 16'h7FFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_wt_err", wt_err, 0);
    check("midrst_in_ready", in_ready, 1);
    foreach (wv[i]) begin
      wv[i] = int'($urandom_range(0, 32766)) - 16383;
      xv[i] = int'($urandom_range(0, 32766)) - 16383;
    end
    bv = int'($urandom_range(0, 32766)) - 16383;
    load(); model();
    run_vec("after_rst", 0, 1, 0);
    repeat (10) @(negedge clk);
    check("no_extra_out", out_valid, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
